sample_output_stage: RTL and testbench
======================================

Name: sample_output_stage

Overview:
- Parametrised successor to the current sample output path. Takes a 2-channel signed sample pair per sample tick and conditions it: arithmetic scale, optional mono mix, clamp, optional ring modulation.
- Commits the two conditioned words to a double buffer, which feeds an internal I2S transmitter to the stereo DAC.
- Sits between the additive oscillator summing logic and the DAC pins.

Parameters:
- IN_WIDTH, 32, width of signed input samples.
- OUT_WIDTH, 16, width of signed DAC word; must be 8..24.
- GAIN_SHIFT, 2, arithmetic right shift applied to each input.
- SAMPLE_LIMIT, 20000, symmetric clamp magnitude; must be ≤ 2^(OUT_WIDTH-1)-1.
- RM_SHIFT, 15, right shift applied to the ring-mod product.
- RM_LATENCY, 2, ring-mod multiplier pipeline depth in clocks; must be ≥1.
- BCLK_DIV, 2, half-period of the I2S bit clock in i_Clock cycles; must be ≥1.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  one-cycle strobe; sample pair valid
- i_Sample_L  in  IN_WIDTH  signed left sample
- i_Sample_R  in  IN_WIDTH  signed right sample
- i_Mode  in  2  0 stereo, 1 mix, 2 ring-mod (R := L*R), 3 reserved (treated as stereo)
- o_Busy  out  1  conditioning in progress; i_Start ignored while high
- o_Done  out  1  one-cycle pulse on commit
- o_Clip  out  2  [0]=L, [1]=R clamped in last commit; held until next commit
- o_Overrun  out  1  one-cycle pulse: commit overwrote an unconsumed pair
- o_I2S_LR_Clock  out  1  word select, low = left
- o_I2S_Bit_Clock  out  1  bit clock
- o_I2S_Data  out  1  serial data

Behaviour:
- Reset: all outputs 0, FSM IDLE, pending flag clear, buffers and shift register 0, BCLK divider and bit counter 0. Reset mid-operation abandons the pair without committing it.
- FSM: IDLE → SCALE → [MIX if mode 1] → LIMIT → [RING → RING_LIMIT if mode 2] → COMMIT → IDLE.
- IDLE: on i_Start, latch samples and mode, then go to SCALE. o_Busy is high in every state except IDLE.
- SCALE: each channel := input >>> GAIN_SHIFT, arithmetic, kept at IN_WIDTH.
- MIX: L := L + R, computed in IN_WIDTH+1 bits, no halving. R := same value.
- LIMIT: clamp each channel to [-SAMPLE_LIMIT, +SAMPLE_LIMIT]. Set the per-channel clip bit if the clamp was active.
- RING: signed OUT_WIDTH×OUT_WIDTH multiply through an RM_LATENCY pipeline. R := product >>> RM_SHIFT. L unchanged.
- RING_LIMIT: clamp R again. R's clip bit is ORed with the LIMIT result.
- COMMIT: truncate each channel to OUT_WIDTH, write the pending buffer, set the pending flag, pulse o_Done, update o_Clip.
- Latency, counted in edges after the edge that samples i_Start: stereo 3, mix 4, ring 4+RM_LATENCY.
- If the pending flag is already set at COMMIT, overwrite the buffer and pulse o_Overrun.
- I2S timing:
  - BCLK toggles every BCLK_DIV clocks. A frame is 64 BCLK periods.
  - LRCLK changes on the BCLK falling edge. Low for 32 periods (left), high for 32 (right).
  - Data is MSB first with a one-BCLK delay after the LRCLK edge. Word is left-justified in the 32-bit slot, zero-padded.
- Frame load: at the BCLK falling edge where LRCLK goes low, the serializer loads the pending pair and clears the flag. If no pair is pending, it replays the previous pair.
- Same-cycle COMMIT and frame load: the serializer takes the old pending pair. The new pair becomes pending, the flag stays set, and there is no overrun.
- Pending flag clear at COMMIT: no overrun.

Optional Feature:
- SAMPLE_OUT_OFFSET_BINARY_EN defined: each committed word has its MSB inverted (adds 2^(OUT_WIDTH-1)) for unsigned DACs. Clamp and clip behaviour are unchanged.
- Undefined: two's-complement words are sent unchanged.

Decomposition:
- Package sample_out_pkg holds:
  - mode constants MODE_STEREO, MODE_MIX, MODE_RING
  - FSM state encoding
  - I2S slot width constant (32)
  - clamp function, parameterised by width and limit
- One sub-module, i2s_tx: BCLK/LRCLK generation, frame-start load strobe, shift register. It exposes a load handshake to the parent.
- The ring-mod multiplier stays inline as a pipelined register chain.

Test Plan:
- Stereo: L=40000, R=-100000 → after 3 edges o_Done; words 10000 (0x2710) and -20000 (0xB1E0); o_Clip=2'b10.
- Mix: L=40000, R=20000 → after 4 edges both words 15000; o_Clip=0.
- Ring (RM_LATENCY=2): L=R=65536 → scaled 16384; R=(16384*16384)>>>15=8192; L=16384; o_Done at edge 6.
- Serial check (BCLK_DIV=2): one committed pair L=0x2710, R=0xB1E0 → frame spans 256 clocks; SDATA bits 1..16 after LRCLK fall = 0x2710, bits 17..32 zero; right slot = 0xB1E0.
- Overrun/underrun:
  - Two commits within one frame → o_Overrun pulses once; the second pair is sent.
  - No commits → the prior pair repeats every frame.
- Reset during the RING state → no o_Done; outputs zero; next i_Start behaves normally; i_Start while o_Busy is ignored.

Source files
------------

// File: rtl/sample_out_pkg.sv
// Shared mode codes, FSM encoding, I2S slot width and clamp helpers for the sample output path.
package sample_out_pkg;

    localparam logic [1:0] MODE_STEREO = 2'd0;
    localparam logic [1:0] MODE_MIX    = 2'd1;
    localparam logic [1:0] MODE_RING   = 2'd2;

    localparam int SLOT_W  = 32;
    localparam int CLAMP_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_MIX,
        S_LIMIT,
        S_RING,
        S_RING_LIMIT,
        S_COMMIT
    } state_t;

    // Symmetric clamp; operands are sign-extended to CLAMP_W by the caller.
    function automatic logic signed [CLAMP_W-1:0] clamp_sym(
        input logic signed [CLAMP_W-1:0] x,
        input logic signed [CLAMP_W-1:0] lim
    );
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        return x;
    endfunction

    function automatic logic clamp_hit(
        input logic signed [CLAMP_W-1:0] x,
        input logic signed [CLAMP_W-1:0] lim
    );
        return (x > lim) || (x < -lim);
    endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: bit clock divider, word select, frame-start load strobe and 64-bit serializer.
module i2s_tx
    import sample_out_pkg::*;
#(
    parameter int OUT_WIDTH = 16,
    parameter int BCLK_DIV  = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [OUT_WIDTH-1:0] i_Word_L,
    input  logic [OUT_WIDTH-1:0] i_Word_R,
    output logic                 o_Load,
    output logic                 o_Bit_Clock,
    output logic                 o_LR_Clock,
    output logic                 o_Data
);

    localparam int DIV_W = $clog2(BCLK_DIV + 1);
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam int PAD_W = SLOT_W - OUT_WIDTH;

    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [BIT_W-1:0]    bit_d;
    logic [2*SLOT_W-1:0] sr_q;
    logic                bclk_q;
    logic                lr_q;
    logic                sd_q;
    logic                tick;
    logic                fall;

    assign tick   = (div_q == DIV_W'(BCLK_DIV - 1));
    assign fall   = tick & bclk_q;
    assign bit_d  = bit_q + BIT_W'(1);
    assign o_Load = fall & (bit_q == {BIT_W{1'b1}});

    // Data leaves on BCLK falling edges; the MSB follows the LRCLK edge by one bit,
    // so the load edge still emits the last bit of the previous frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            div_q  <= '0;
            bit_q  <= '0;
            sr_q   <= '0;
            bclk_q <= 1'b0;
            lr_q   <= 1'b0;
            sd_q   <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            if (tick)
                bclk_q <= ~bclk_q;
            if (fall) begin
                bit_q <= bit_d;
                lr_q  <= bit_d[BIT_W-1];
                sd_q  <= sr_q[2*SLOT_W-1];
                if (o_Load)
                    sr_q <= {i_Word_L, {PAD_W{1'b0}}, i_Word_R, {PAD_W{1'b0}}};
                else
                    sr_q <= {sr_q[2*SLOT_W-2:0], 1'b0};
            end
        end
    end

    assign o_Bit_Clock = bclk_q;
    assign o_LR_Clock  = lr_q;
    assign o_Data      = sd_q;

endmodule

// File: rtl/sample_output_stage.sv
// Sample conditioning (scale, mix, clamp, ring-mod) into a double buffer feeding an I2S DAC link.
// Define SAMPLE_OUT_OFFSET_BINARY_EN to send offset-binary words (MSB inverted) for unsigned DACs.
module sample_output_stage
    import sample_out_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int GAIN_SHIFT   = 2,
    parameter int SAMPLE_LIMIT = 20000,
    parameter int RM_SHIFT     = 15,
    parameter int RM_LATENCY   = 2,
    parameter int BCLK_DIV     = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic signed [IN_WIDTH-1:0] i_Sample_L,
    input  logic signed [IN_WIDTH-1:0] i_Sample_R,
    input  logic [1:0]                 i_Mode,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic [1:0]                 o_Clip,
    output logic                       o_Overrun,
    output logic                       o_I2S_LR_Clock,
    output logic                       o_I2S_Bit_Clock,
    output logic                       o_I2S_Data
);

    localparam int PROD_W = 2 * OUT_WIDTH;
    localparam logic signed [CLAMP_W-1:0] LIM = CLAMP_W'(SAMPLE_LIMIT);
`ifdef SAMPLE_OUT_OFFSET_BINARY_EN
    localparam logic [OUT_WIDTH-1:0] FLIP = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`else
    localparam logic [OUT_WIDTH-1:0] FLIP = '0;
`endif

    state_t                    state_q;
    logic [1:0]                mode_q;
    logic signed [IN_WIDTH:0]  l_q;
    logic signed [IN_WIDTH:0]  r_q;
    logic [1:0]                clip_q;
    logic [7:0]                rcnt_q;
    logic signed [PROD_W-1:0]  mul_q [RM_LATENCY];
    logic                      busy_q;
    logic                      done_q;
    logic                      ovr_q;
    logic [1:0]                clip_o_q;
    logic                      pend_q;
    logic [OUT_WIDTH-1:0]      buf_l_q;
    logic [OUT_WIDTH-1:0]      buf_r_q;
    logic                      load;
    logic signed [OUT_WIDTH-1:0] ring_a;
    logic signed [OUT_WIDTH-1:0] ring_b;
    logic signed [CLAMP_W-1:0] l_ext;
    logic signed [CLAMP_W-1:0] r_ext;
    logic signed [CLAMP_W-1:0] rm_ext;

    // After LIMIT both channels fit OUT_WIDTH, so the low bits are the full operands.
    assign ring_a = l_q[OUT_WIDTH-1:0];
    assign ring_b = r_q[OUT_WIDTH-1:0];
    assign l_ext  = CLAMP_W'(l_q);
    assign r_ext  = CLAMP_W'(r_q);
    assign rm_ext = CLAMP_W'(mul_q[RM_LATENCY-1] >>> RM_SHIFT);

    always_ff @(posedge i_Clock) begin
        mul_q[0] <= PROD_W'(ring_a) * PROD_W'(ring_b);
        for (int k = 1; k < RM_LATENCY; k++)
            mul_q[k] <= mul_q[k-1];
    end

    always_ff @(posedge i_Clock) begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
        if (i_Reset) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_STEREO;
            clip_q   <= '0;
            rcnt_q   <= '0;
            busy_q   <= 1'b0;
            clip_o_q <= '0;
            pend_q   <= 1'b0;
            buf_l_q  <= '0;
            buf_r_q  <= '0;
        end else begin
            if (load)
                pend_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_Start) begin
                    l_q     <= (IN_WIDTH+1)'(i_Sample_L);
                    r_q     <= (IN_WIDTH+1)'(i_Sample_R);
                    mode_q  <= (i_Mode == MODE_MIX || i_Mode == MODE_RING) ? i_Mode : MODE_STEREO;
                    busy_q  <= 1'b1;
                    state_q <= S_SCALE;
                end
                S_SCALE: begin
                    l_q     <= l_q >>> GAIN_SHIFT;
                    r_q     <= r_q >>> GAIN_SHIFT;
                    state_q <= (mode_q == MODE_MIX) ? S_MIX : S_LIMIT;
                end
                S_MIX: begin
                    l_q     <= l_q + r_q;
                    r_q     <= l_q + r_q;
                    state_q <= S_LIMIT;
                end
                S_LIMIT: begin
                    l_q     <= (IN_WIDTH+1)'(clamp_sym(l_ext, LIM));
                    r_q     <= (IN_WIDTH+1)'(clamp_sym(r_ext, LIM));
                    clip_q  <= {clamp_hit(r_ext, LIM), clamp_hit(l_ext, LIM)};
                    rcnt_q  <= '0;
                    state_q <= (mode_q == MODE_RING) ? S_RING : S_COMMIT;
                end
                // Wait for the operands to reach the end of the multiplier chain.
                S_RING: begin
                    if (rcnt_q == 8'(RM_LATENCY - 1))
                        state_q <= S_RING_LIMIT;
                    else
                        rcnt_q <= rcnt_q + 8'd1;
                end
                S_RING_LIMIT: begin
                    r_q       <= (IN_WIDTH+1)'(clamp_sym(rm_ext, LIM));
                    clip_q[1] <= clip_q[1] | clamp_hit(rm_ext, LIM);
                    state_q   <= S_COMMIT;
                end
                // A coincident frame load takes the old buffer, so the new pair stays pending.
                S_COMMIT: begin
                    buf_l_q  <= l_q[OUT_WIDTH-1:0] ^ FLIP;
                    buf_r_q  <= r_q[OUT_WIDTH-1:0] ^ FLIP;
                    pend_q   <= 1'b1;
                    ovr_q    <= pend_q & ~load;
                    done_q   <= 1'b1;
                    clip_o_q <= clip_q;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    i2s_tx #(
        .OUT_WIDTH (OUT_WIDTH),
        .BCLK_DIV  (BCLK_DIV)
    ) u_i2s_tx (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Word_L    (buf_l_q),
        .i_Word_R    (buf_r_q),
        .o_Load      (load),
        .o_Bit_Clock (o_I2S_Bit_Clock),
        .o_LR_Clock  (o_I2S_LR_Clock),
        .o_Data      (o_I2S_Data)
    );

    assign o_Busy    = busy_q;
    assign o_Done    = done_q;
    assign o_Clip    = clip_o_q;
    assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_sample_output_stage.sv
// Bench for sample_output_stage: directed and random pairs against an arithmetic model plus an I2S frame decoder.
`timescale 1ns/1ps
module tb_sample_output_stage;

    localparam int IN_WIDTH     = 32;
    localparam int OUT_WIDTH    = 16;
    localparam int GAIN_SHIFT   = 2;
    localparam int SAMPLE_LIMIT = 20000;
    localparam int RM_SHIFT     = 15;
    localparam int RM_LATENCY   = 2;
    localparam int BCLK_DIV     = 2;
    localparam int FRAME_CLKS   = 2 * BCLK_DIV * 64;
    localparam longint LIM      = SAMPLE_LIMIT;
`ifdef SAMPLE_OUT_OFFSET_BINARY_EN
    localparam logic [15:0] FLIP = 16'h8000;
`else
    localparam logic [15:0] FLIP = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed [31:0] sl = '0;
    logic signed [31:0] sr = '0;
    logic [1:0] mode = '0;
    logic busy, done, ovr, lrc, bck, sdat;
    logic [1:0] clip;

    sample_output_stage #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .GAIN_SHIFT(GAIN_SHIFT),
        .SAMPLE_LIMIT(SAMPLE_LIMIT), .RM_SHIFT(RM_SHIFT), .RM_LATENCY(RM_LATENCY),
        .BCLK_DIV(BCLK_DIV)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start),
        .i_Sample_L(sl), .i_Sample_R(sr), .i_Mode(mode),
        .o_Busy(busy), .o_Done(done), .o_Clip(clip), .o_Overrun(ovr),
        .o_I2S_LR_Clock(lrc), .o_I2S_Bit_Clock(bck), .o_I2S_Data(sdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] wl;
        logic [15:0] wr;
        logic [1:0]  clip;
        int          due;
    } txn_t;

    txn_t        expq[$];
    logic [31:0] loadq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rst_seen = 1'b1;
    int last_load = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint clampv(input longint x, output bit hit);
        hit = (x > LIM) || (x < -LIM);
        if (x > LIM) return LIM;
        if (x < -LIM) return -LIM;
        return x;
    endfunction

    function automatic txn_t model(input int l, input int r, input logic [1:0] m, input int start_edge);
        longint a, b, p;
        bit ha, hb, hp;
        txn_t t;
        a = longint'(l) >>> GAIN_SHIFT;
        b = longint'(r) >>> GAIN_SHIFT;
        if (m == 2'd1) begin
            a = a + b;
            b = a;
        end
        a = clampv(a, ha);
        b = clampv(b, hb);
        t.clip = {hb, ha};
        if (m == 2'd2) begin
            p = (a * b) >>> RM_SHIFT;
            b = clampv(p, hp);
            t.clip[1] = t.clip[1] | hp;
        end
        t.wl  = a[15:0] ^ FLIP;
        t.wr  = b[15:0] ^ FLIP;
        t.due = start_edge + ((m == 2'd1) ? 4 : (m == 2'd2) ? 4 + RM_LATENCY : 3);
        return t;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Monitor: buffer/pending model, commit checks and I2S frame decoding, sampled on the falling edge.
    initial begin
        logic [31:0] m_buf;
        logic [31:0] ep;
        logic [63:0] fsr;
        bit m_pend, p_bclk, p_lr, lr_at_rise, first_dec, is_load;
        txn_t t;
        m_buf = '0; fsr = '0; m_pend = 0; p_bclk = 0; p_lr = 0; lr_at_rise = 0; first_dec = 1;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check("reset_outputs", {busy, done, ovr, clip, lrc, bck, sdat}, 0);
                expq.delete();
                loadq.delete();
                m_buf = '0; fsr = '0; m_pend = 0; p_bclk = 0; p_lr = 0;
                lr_at_rise = 0; first_dec = 1; last_load = -1;
            end else begin
                is_load = p_lr && !lrc;
                if (is_load) begin
                    if (last_load >= 0)
                        check("frame_length", cyc - last_load, FRAME_CLKS);
                    last_load = cyc;
                    loadq.push_back(m_buf);
                end
                if (done) begin
                    if (expq.size() == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        t = expq.pop_front();
                        check("done_cycle", cyc, t.due);
                        check("clip", clip, t.clip);
                        check("overrun", ovr, m_pend && !is_load);
                        m_buf  = {t.wl, t.wr};
                        m_pend = 1;
                    end
                end else begin
                    if (ovr)
                        check("overrun_without_done", ovr, 0);
                    if (is_load)
                        m_pend = 0;
                end
                if (bck && !p_bclk) begin
                    fsr = {fsr[62:0], sdat};
                    if (lr_at_rise && !lrc) begin
                        if (first_dec) begin
                            first_dec = 0;
                        end else if (loadq.size() == 0) begin
                            check("frame_unexpected", 1, 0);
                        end else begin
                            ep = loadq.pop_front();
                            check("i2s_frame", fsr, {ep[31:16], 16'h0000, ep[15:0], 16'h0000});
                        end
                    end
                    lr_at_rise = lrc;
                end
                p_bclk = bck;
                p_lr   = lrc;
            end
        end
    end

    task automatic send(input int l, input int r, input logic [1:0] m);
        @(negedge clk);
        expq.push_back(model(l, r, m, cyc + 1));
        sl = l; sr = r; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && expq.size() != 0; i++) @(negedge clk);
        check("txn_drain", expq.size(), 0);
    endtask

    task automatic wait_load();
        int old;
        old = last_load;
        for (int i = 0; i < 3 * FRAME_CLKS && last_load == old; i++) @(negedge clk);
        check("load_seen", last_load != old, 1);
    endtask

    initial begin
        int ll;
        int l, r;
        logic [1:0] m;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed: stereo, mix and ring examples, each sent in its own frame.
        wait_load(); repeat (4) @(negedge clk);
        send(40000, -100000, 2'd0); wait_idle();
        wait_load(); repeat (4) @(negedge clk);
        send(40000, 20000, 2'd1);
        check("busy_high", busy, 1);
        sl = 7; sr = 9; mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        wait_load(); repeat (4) @(negedge clk);
        send(65536, 65536, 2'd2); wait_idle();

        // No commits: previous pair is replayed.
        wait_load(); wait_load(); wait_load();

        // Two commits in one frame: overrun, second pair sent.
        wait_load(); repeat (4) @(negedge clk);
        send(1000, 2000, 2'd0); wait_idle();
        send(-5000, 7000, 2'd1); wait_idle();

        // Commit landing on the frame-load edge while a pair is already pending.
        wait_load(); repeat (4) @(negedge clk);
        send(111, 222, 2'd0); wait_idle();
        ll = last_load;
        for (int i = 0; i < FRAME_CLKS && cyc < ll + FRAME_CLKS - 5; i++) @(negedge clk);
        send(300, -400, 2'd0); wait_idle();
        wait_load(); wait_load();

        // Reset while in RING: pair abandoned, then normal operation resumes.
        wait_load(); repeat (4) @(negedge clk);
        send(65536, 30000, 2'd2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_done_after_reset", done, 0);
        wait_load(); repeat (4) @(negedge clk);
        send(-400000, 123456, 2'd3); wait_idle();
        wait_load(); wait_load();

        // Random pairs, modes and gaps.
        for (int k = 0; k < 24; k++) begin
            l = int'($urandom);
            r = int'($urandom);
            if ($urandom_range(1, 0) == 1) l = l >>> 12;
            if ($urandom_range(1, 0) == 1) r = r >>> 12;
            m = 2'($urandom_range(3, 0));
            send(l, r, m);
            wait_idle();
            repeat ($urandom_range(150, 0)) @(negedge clk);
        end
        wait_load(); wait_load(); wait_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
